// File: rtl/mem_bridge_pkg.sv
// Shared types for the core-to-memory bridge: FSM states, RV32I load/store funct3
// encodings and the legality / alignment helpers used by the bridge and its lane aligner.
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_bridge_state_t;

    typedef enum logic [2:0] {
        LB_F3  = 3'b000,
        LH_F3  = 3'b001,
        LW_F3  = 3'b010,
        LBU_F3 = 3'b100,
        LHU_F3 = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB_F3 = 3'b000,
        SH_F3 = 3'b001,
        SW_F3 = 3'b010
    } store_funct3_t;

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        logic legal;
        if (is_store) begin
            case (funct3)
                SB_F3, SH_F3, SW_F3: legal = 1'b1;
                default:             legal = 1'b0;
            endcase
        end else begin
            case (funct3)
                LB_F3, LH_F3, LW_F3, LBU_F3, LHU_F3: legal = 1'b1;
                default:                             legal = 1'b0;
            endcase
        end
        return legal;
    endfunction

    // funct3[1:0] encodes the access size identically for loads and stores.
    function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic mis;
        case (funct3[1:0])
            2'b01:   mis = offset[0];
            2'b10:   mis = (offset != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: places store data/mask on the addressed lanes and
// extracts plus sign/zero-extends load data from a raw memory word.
module mem_lane_align
    import mem_bridge_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [4:0]  shamt_s;
    logic [31:0] rshift_s;

    assign shamt_s    = {offset, 3'b000};
    assign rshift_s   = rdata >> shamt_s;
    assign misaligned = addr_misaligned(funct3, offset);

    // Store mask and lane-shifted store data
    always_comb begin
        wmask      = 4'b1111;
        wdata_lane = wdata;
        case (funct3[1:0])
            2'b00: begin
                wmask      = 4'b0001 << offset;
                wdata_lane = {24'd0, wdata[7:0]} << shamt_s;
            end
            2'b01: begin
                wmask      = 4'b0011 << offset;
                wdata_lane = {16'd0, wdata[15:0]} << shamt_s;
            end
            default: begin
                wmask      = 4'b1111;
                wdata_lane = wdata;
            end
        endcase
    end

    // Load extraction with sign or zero extension
    always_comb begin
        rdata_ext = 32'd0;
        case (funct3)
            LB_F3:   rdata_ext = {{24{rshift_s[7]}}, rshift_s[7:0]};
            LH_F3:   rdata_ext = {{16{rshift_s[15]}}, rshift_s[15:0]};
            LW_F3:   rdata_ext = rdata;
            LBU_F3:  rdata_ext = {24'd0, rshift_s[7:0]};
            LHU_F3:  rdata_ext = {16'd0, rshift_s[15:0]};
            default: rdata_ext = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_bridge.sv
// Bridges a held core load/store request onto a valid/ready memory request channel and
// returns a single-cycle response with extended load data or an error flag.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 32'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_read,
    input  logic        core_write,
    input  logic [31:0] core_addr,
    input  logic [2:0]  core_funct3,
    input  logic [31:0] core_wdata,
    output logic        core_resp,
    output logic        core_err,
    output logic [31:0] core_rdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 32'd2);

    mem_bridge_state_t state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc_s;
    logic [1:0]        off_q, off_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [3:0]        mem_wmask_q, mem_wmask_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              core_resp_q, core_resp_d;
    logic              core_err_q, core_err_d;
    logic [31:0]       core_rdata_q, core_rdata_d;

    logic [2:0]        al_funct3_s;
    logic [1:0]        al_off_s;
    logic [3:0]        al_wmask_s;
    logic [31:0]       al_wdata_s;
    logic [31:0]       al_rdata_s;
    logic              al_misal_s;
    logic              timeout_hit_s;

    // In IDLE the aligner checks the live request; afterwards it extracts with the captured fields.
    assign al_funct3_s = (state_q == IDLE) ? core_funct3 : funct3_q;
    assign al_off_s    = (state_q == IDLE) ? core_addr[1:0] : off_q;

    mem_lane_align u_align (
        .funct3     (al_funct3_s),
        .offset     (al_off_s),
        .wdata      (core_wdata),
        .rdata      (mem_rdata),
        .wmask      (al_wmask_s),
        .wdata_lane (al_wdata_s),
        .rdata_ext  (al_rdata_s),
        .misaligned (al_misal_s)
    );

    assign cnt_inc_s     = cnt_q + CNT_W'(1);
    assign timeout_hit_s = (TIMEOUT_CYC != 32'd0) && (cnt_inc_s >= CNT_W'(TIMEOUT_CYC));

    // Next-state, capture and registered-output computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        off_d        = off_q;
        funct3_d     = funct3_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wmask_d  = mem_wmask_q;
        mem_wdata_d  = mem_wdata_q;
        core_err_d   = 1'b0;
        core_rdata_d = 32'd0;
        case (state_q)
            IDLE: begin
                if (core_read && core_write) begin
                    state_d    = DONE;
                    core_err_d = 1'b1;
                end else if (core_read || core_write) begin
                    cnt_d    = {CNT_W{1'b0}};
                    off_d    = core_addr[1:0];
                    funct3_d = core_funct3;
                    if (al_misal_s || !funct3_legal(core_write, core_funct3)) begin
                        state_d    = DONE;
                        core_err_d = 1'b1;
                    end else begin
                        state_d     = REQ;
                        mem_we_d    = core_write;
                        mem_addr_d  = {core_addr[31:2], 2'b00};
                        mem_wmask_d = core_write ? al_wmask_s : 4'b0000;
                        mem_wdata_d = core_write ? al_wdata_s : 32'd0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            // An accept or a response in the final budget cycle wins over the timeout,
            // so an accepted transaction is never abandoned before it can complete.
            REQ: begin
                cnt_d = cnt_inc_s;
                if (mem_ready) begin
                    state_d = WAIT;
                end else if (timeout_hit_s) begin
                    state_d    = DONE;
                    core_err_d = 1'b1;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc_s;
                if (mem_rvalid) begin
                    state_d      = DONE;
                    core_rdata_d = mem_we_q ? 32'd0 : al_rdata_s;
                end else if (timeout_hit_s) begin
                    state_d    = DONE;
                    core_err_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        mem_valid_d = (state_d == REQ);
        core_resp_d = (state_d == DONE);
    end

    // State, capture and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            off_q        <= 2'd0;
            funct3_q     <= 3'd0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wmask_q  <= 4'd0;
            mem_wdata_q  <= 32'd0;
            core_resp_q  <= 1'b0;
            core_err_q   <= 1'b0;
            core_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            funct3_q     <= funct3_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wmask_q  <= mem_wmask_d;
            mem_wdata_q  <= mem_wdata_d;
            core_resp_q  <= core_resp_d;
            core_err_q   <= core_err_d;
            core_rdata_q <= core_rdata_d;
        end
    end

    assign mem_valid  = mem_valid_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wmask  = mem_wmask_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_resp  = core_resp_q;
    assign core_err   = core_err_q;
    assign core_rdata = core_rdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: directed vector table, reset-in-flight sequence and
// randomized transactions scored against a behavioural model of the load/store rules.
module tb_mem_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_read, core_write;
    logic [31:0] core_addr, core_wdata;
    logic [2:0]  core_funct3;
    logic        core_resp, core_err;
    logic [31:0] core_rdata;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    always #5 clk = ~clk;

    mem_bridge #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_read(core_read), .core_write(core_write), .core_addr(core_addr),
        .core_funct3(core_funct3), .core_wdata(core_wdata),
        .core_resp(core_resp), .core_err(core_err), .core_rdata(core_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rdy;       // valid cycles before ready is given
        int          rv;        // cycles from accept to rvalid, <0 = never
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_acc;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_wdata;
        int          exp_vcyc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int          obs_lat, obs_acc, obs_vcyc;
    logic        obs_err, obs_we, obs_stable, obs_pulse, stray;
    logic [31:0] obs_rdata, obs_addr, obs_wdata;
    logic [3:0]  obs_wmask;

    vec_t vecs [0:14];
    vec_t rnd_v, exp_v;
    int   sel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Behavioural reference: sizes, lanes and latency derived from arithmetic on the request.
    function automatic vec_t model(input vec_t v);
        vec_t        e;
        int          size, off;
        logic        legal;
        logic [31:0] m, val;
        e = v;
        off = int'(v.addr[1:0]);
        case (v.f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        legal = v.wr ? (v.f3 <= 3'd2) : (size != 0);
        e.exp_err = 1'b0; e.exp_rdata = 32'd0; e.exp_acc = 0; e.exp_addr = 32'd0;
        e.exp_we = 1'b0; e.exp_wmask = 4'd0; e.exp_wdata = 32'd0; e.exp_vcyc = 0;
        if ((v.rd && v.wr) || !legal || (off % size != 0)) begin
            e.exp_lat = 1;
            e.exp_err = 1'b1;
            return e;
        end
        m = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        e.exp_addr = v.addr & 32'hFFFF_FFFC;
        e.exp_we   = v.wr;
        if (v.wr) begin
            e.exp_wmask = 4'(((1 << size) - 1) << off);
            e.exp_wdata = (v.wdata & m) << (8 * off);
        end
        if (v.rdy >= TO) begin
            e.exp_vcyc = TO;
            e.exp_lat  = TO + 1;
            e.exp_err  = 1'b1;
            return e;
        end
        e.exp_acc  = 1;
        e.exp_vcyc = v.rdy + 1;
        if (v.rv < 0 || (1 + v.rdy + v.rv) > TO) begin
            e.exp_lat = TO + 1;
            e.exp_err = 1'b1;
            return e;
        end
        e.exp_lat = 2 + v.rdy + v.rv;
        if (v.rd) begin
            val = (v.rdata >> (8 * off)) & m;
            if (!v.f3[2] && val[8 * size - 1]) val = val | ~m;
            e.exp_rdata = val;
        end
        return e;
    endfunction

    // Drives one request and plays the memory side; records what the DUT did.
    task automatic run_txn(input vec_t v);
        int acc_t;
        acc_t = -1;
        obs_lat = -1; obs_acc = 0; obs_vcyc = 0; obs_stable = 1'b1;
        obs_err = 1'b0; obs_rdata = 32'd0; obs_addr = 32'd0; obs_we = 1'b0;
        obs_wmask = 4'd0; obs_wdata = 32'd0;
        core_read = v.rd; core_write = v.wr; core_addr = v.addr;
        core_funct3 = v.f3; core_wdata = v.wdata; mem_rdata = v.rdata;
        for (int t = 1; t <= 40 && obs_lat < 0; t++) begin
            @(posedge clk); #1;
            mem_rvalid = (acc_t >= 0) && (v.rv >= 0) && (t == acc_t + v.rv);
            mem_ready  = 1'b0;
            if (core_resp) begin
                obs_lat = t; obs_err = core_err; obs_rdata = core_rdata;
            end
            if (mem_valid) begin
                if (obs_vcyc == 0) begin
                    obs_addr = mem_addr; obs_we = mem_we; obs_wmask = mem_wmask; obs_wdata = mem_wdata;
                end else if ({mem_addr, mem_we, mem_wmask, mem_wdata} !== {obs_addr, obs_we, obs_wmask, obs_wdata}) begin
                    obs_stable = 1'b0;
                end
                obs_vcyc++;
                if (obs_vcyc > v.rdy) begin
                    mem_ready = 1'b1; obs_acc++; acc_t = t;
                end
            end
        end
        @(posedge clk); #1;
        obs_pulse = core_resp;
        core_read = 1'b0; core_write = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic check_txn(input vec_t e, input string tag);
        chk($sformatf("%s.latency", tag), 32'(obs_lat), 32'(e.exp_lat));
        chk($sformatf("%s.err", tag), {31'd0, obs_err}, {31'd0, e.exp_err});
        chk($sformatf("%s.rdata", tag), obs_rdata, e.exp_rdata);
        chk($sformatf("%s.accepts", tag), 32'(obs_acc), 32'(e.exp_acc));
        chk($sformatf("%s.valid_cycles", tag), 32'(obs_vcyc), 32'(e.exp_vcyc));
        chk($sformatf("%s.resp_one_cycle", tag), {31'd0, obs_pulse}, 32'd0);
        if (e.exp_vcyc > 0) begin
            chk($sformatf("%s.mem_addr", tag), obs_addr, e.exp_addr);
            chk($sformatf("%s.mem_we", tag), {31'd0, obs_we}, {31'd0, e.exp_we});
            chk($sformatf("%s.mem_wmask", tag), {28'd0, obs_wmask}, {28'd0, e.exp_wmask});
            chk($sformatf("%s.stable", tag), {31'd0, obs_stable}, 32'd1);
            if (e.exp_we) chk($sformatf("%s.mem_wdata", tag), obs_wdata, e.exp_wdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; core_read = 1'b0; core_write = 1'b0; core_addr = 32'd0;
        core_funct3 = 3'd0; core_wdata = 32'd0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {31'd0, |{core_resp, core_err, core_rdata, mem_valid, mem_we,
                                       mem_addr, mem_wmask, mem_wdata}}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //            rd    wr    addr          f3      wdata          rdata         rdy rv  lat err   rdata         acc addr        we    wmask    wdata         vcyc
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0100, 3'b010, 32'h0,         32'hDEADBEEF, 0,  1,  3, 1'b0, 32'hDEADBEEF, 1, 32'h100, 1'b0, 4'b0000, 32'h0,        1};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0203, 3'b000, 32'h0000_00AB, 32'h0,        0,  1,  3, 1'b0, 32'h0,        1, 32'h200, 1'b1, 4'b1000, 32'hAB00_0000, 1};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0302, 3'b001, 32'h0,         32'h8001_1234, 0, 1,  3, 1'b0, 32'hFFFF_8001, 1, 32'h300, 1'b0, 4'b0000, 32'h0,       1};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0302, 3'b101, 32'h0,         32'h8001_1234, 0, 1,  3, 1'b0, 32'h0000_8001, 1, 32'h300, 1'b0, 4'b0000, 32'h0,       1};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0401, 3'b010, 32'h0,         32'h0,        0,  1,  1, 1'b1, 32'h0,        0, 32'h0,   1'b0, 4'b0000, 32'h0,        0};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0500, 3'b010, 32'h1234_5678, 32'h0,        3,  2,  7, 1'b0, 32'h0,        1, 32'h500, 1'b1, 4'b1111, 32'h1234_5678, 4};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0600, 3'b010, 32'h0,         32'h0,        0, -1,  9, 1'b1, 32'h0,        1, 32'h600, 1'b0, 4'b0000, 32'h0,        1};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_0700, 3'b010, 32'h0,         32'h0,        0,  1,  1, 1'b1, 32'h0,        0, 32'h0,   1'b0, 4'b0000, 32'h0,        0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0700, 3'b011, 32'h0,         32'h0,        0,  1,  1, 1'b1, 32'h0,        0, 32'h0,   1'b0, 4'b0000, 32'h0,        0};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_0700, 3'b100, 32'h0,         32'h0,        0,  1,  1, 1'b1, 32'h0,        0, 32'h0,   1'b0, 4'b0000, 32'h0,        0};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0702, 3'b001, 32'hCAFE_BEEF, 32'h0,        0,  1,  3, 1'b0, 32'h0,        1, 32'h700, 1'b1, 4'b1100, 32'hBEEF_0000, 1};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0801, 3'b000, 32'h0,         32'h1234_8056, 1, 3,  6, 1'b0, 32'hFFFF_FF80, 1, 32'h800, 1'b0, 4'b0000, 32'h0,       2};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_0803, 3'b100, 32'h0,         32'hF000_0000, 2, 1,  5, 1'b0, 32'h0000_00F0, 1, 32'h800, 1'b0, 4'b0000, 32'h0,       3};
        vecs[13] = '{1'b0, 1'b1, 32'h0000_0001, 3'b001, 32'h0,         32'h0,        0,  1,  1, 1'b1, 32'h0,        0, 32'h0,   1'b0, 4'b0000, 32'h0,        0};
        vecs[14] = '{1'b1, 1'b0, 32'h0000_0A00, 3'b010, 32'h0,         32'h0,      100,  1,  9, 1'b1, 32'h0,        0, 32'hA00, 1'b0, 4'b0000, 32'h0,        8};

        for (int i = 0; i < 15; i++) begin
            run_txn(vecs[i]);
            check_txn(vecs[i], $sformatf("v%0d", i));
        end

        // Reset while waiting for the response, then a stray rvalid, then a clean transaction.
        core_read = 1'b1; core_write = 1'b0; core_addr = 32'h0000_0900; core_funct3 = 3'b010;
        mem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        chk("rst_seq.req_valid", {31'd0, mem_valid}, 32'd1);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        chk("rst_seq.wait_addr", mem_addr, 32'h0000_0900);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_seq.outputs_zero", {31'd0, |{core_resp, core_err, core_rdata, mem_valid, mem_we,
                                              mem_addr, mem_wmask, mem_wdata}}, 32'd0);
        core_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        stray = 1'b0;
        repeat (3) begin
            stray = stray | core_resp | mem_valid;
            @(posedge clk); #1;
        end
        chk("rst_seq.late_rvalid_ignored", {31'd0, stray}, 32'd0);
        rnd_v = '{1'b1, 1'b0, 32'h0000_0904, 3'b010, 32'h0, 32'h1122_3344, 0, 1,
                  0, 1'b0, 32'h0, 0, 32'h0, 1'b0, 4'b0000, 32'h0, 0};
        exp_v = model(rnd_v);
        run_txn(rnd_v);
        check_txn(exp_v, "rst_seq.after");

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 15);
            rnd_v.rd    = (sel < 7) || (sel == 15);
            rnd_v.wr    = (sel >= 7);
            rnd_v.f3    = 3'($urandom_range(0, 7));
            rnd_v.addr  = $urandom;
            rnd_v.wdata = $urandom;
            rnd_v.rdata = $urandom;
            rnd_v.rdy   = $urandom_range(0, 2);
            rnd_v.rv    = $urandom_range(1, 3);
            exp_v = model(rnd_v);
            run_txn(rnd_v);
            check_txn(exp_v, $sformatf("r%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
